// File: rtl/card_pkg.sv
// Shared card constants and scoring helpers for the baccarat card datapath.
package card_pkg;
  localparam int RANK_W    = 4;
  localparam int NUM_SLOTS = 6;
  localparam logic [RANK_W-1:0] RANK_EMPTY = 4'd0;
  localparam logic [RANK_W-1:0] RANK_MIN   = 4'd1;
  localparam logic [RANK_W-1:0] RANK_MAX   = 4'd13;

  // Slot order doubles as strobe priority: lower index wins.
  typedef enum logic [2:0] {
    SLOT_P1 = 3'd0, SLOT_D1 = 3'd1, SLOT_P2 = 3'd2,
    SLOT_D2 = 3'd3, SLOT_P3 = 3'd4, SLOT_D3 = 3'd5
  } slot_e;

  function automatic logic [3:0] card_value(input logic [RANK_W-1:0] rank);
    return (rank <= 4'd9) ? rank : 4'd0;
  endfunction

  function automatic logic [3:0] score_mod10(input logic [4:0] sum);
    logic [4:0] t;
    t = sum;
    if (t >= 5'd20)      t = t - 5'd20;
    else if (t >= 5'd10) t = t - 5'd10;
    return t[3:0];
  endfunction
endpackage

// File: rtl/card_shoe.sv
// Tracked shoe: free-running rank counter, per-rank counts and wrap-around draw search.
module card_shoe
  import card_pkg::*;
#(
  parameter int NUM_DECKS = 1
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              draw,
  input  logic              refill_req,
  output logic [RANK_W-1:0] drawn_rank,
  output logic              empty,
  output logic [7:0]        cards_left
);
  localparam logic [4:0] FULL_RANK = 5'(4 * NUM_DECKS);
  localparam logic [7:0] FULL_SHOE = 8'(52 * NUM_DECKS);

  logic [RANK_W-1:0] r_ctr;
  logic [4:0]        r_remaining [RANK_MIN:RANK_MAX];
  logic [7:0]        r_cards_left;
  logic [4:0]        w_idx;
  logic [RANK_W-1:0] w_rank;
  logic              w_found;

  // First rank at or after ctr (wrapping 13 -> 1) that still has cards.
  always_comb begin
    w_idx   = '0;
    w_rank  = RANK_EMPTY;
    w_found = 1'b0;
    for (int i = 0; i < 13; i++) begin
      w_idx = {1'b0, r_ctr} + 5'(i);
      if (w_idx > 5'd13) w_idx = w_idx - 5'd13;
      if (!w_found && r_remaining[w_idx[3:0]] != 5'd0) begin
        w_found = 1'b1;
        w_rank  = w_idx[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_ctr        <= RANK_MIN;
      r_cards_left <= FULL_SHOE;
      for (int r = 1; r <= 13; r++) r_remaining[r] <= FULL_RANK;
    end else begin
      r_ctr <= (r_ctr == RANK_MAX) ? RANK_MIN : r_ctr + 4'd1;
      if (refill_req) begin
        r_cards_left <= FULL_SHOE;
        for (int r = 1; r <= 13; r++) r_remaining[r] <= FULL_RANK;
      end else if (draw && w_found) begin
        r_cards_left <= r_cards_left - 8'd1;
        for (int r = 1; r <= 13; r++)
          if (w_rank == 4'(r)) r_remaining[r] <= r_remaining[r] - 5'd1;
      end
    end
  end

  assign drawn_rank = w_rank;
  assign empty      = (r_cards_left == 8'd0);
  assign cards_left = r_cards_left;
endmodule

// File: rtl/card_datapath.sv
// Baccarat card datapath: strobe arbitration, card registers, scores and protocol checks.
module card_datapath
  import card_pkg::*;
#(
  parameter int NUM_DECKS = 1
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              load_pcard1,
  input  logic              load_pcard2,
  input  logic              load_pcard3,
  input  logic              load_dcard1,
  input  logic              load_dcard2,
  input  logic              load_dcard3,
  input  logic              new_hand,
  output logic [RANK_W-1:0] pcard1,
  output logic [RANK_W-1:0] pcard2,
  output logic [RANK_W-1:0] pcard3,
  output logic [RANK_W-1:0] dcard1,
  output logic [RANK_W-1:0] dcard2,
  output logic [RANK_W-1:0] dcard3,
  output logic [3:0]        pscore,
  output logic [3:0]        dscore,
  output logic [7:0]        cards_left,
  output logic              protocol_err,
  output logic              shoe_empty
);
  logic [RANK_W-1:0]    r_card [NUM_SLOTS];
  logic                 r_protocol_err;
  logic                 r_shoe_empty;
  logic [NUM_SLOTS-1:0] w_ld, w_sel, w_nonempty;
  logic                 w_multi, w_load, w_overwrite, w_empty, w_refill;
  logic [RANK_W-1:0]    w_drawn_rank;
  logic [7:0]           w_cards_left;

  assign w_ld = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
  // Isolating the lowest set bit picks the highest-priority strobe.
  assign w_sel       = w_ld & (~w_ld + 6'd1);
  assign w_multi     = (w_ld & (w_ld - 6'd1)) != 6'd0;
  assign w_load      = (|w_ld) && !new_hand;
  assign w_overwrite = |(w_sel & w_nonempty);
  assign w_refill    = new_hand && (w_cards_left < 8'd6);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign w_nonempty[gi] = (r_card[gi] != RANK_EMPTY);
    end
  endgenerate

  card_shoe #(.NUM_DECKS(NUM_DECKS)) u_shoe (
    .clk        (clk),
    .resetb     (resetb),
    .draw       (w_load),
    .refill_req (w_refill),
    .drawn_rank (w_drawn_rank),
    .empty      (w_empty),
    .cards_left (w_cards_left)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int k = 0; k < NUM_SLOTS; k++) r_card[k] <= RANK_EMPTY;
      r_protocol_err <= 1'b0;
      r_shoe_empty   <= 1'b0;
    end else begin
      if (new_hand) begin
        for (int k = 0; k < NUM_SLOTS; k++) r_card[k] <= RANK_EMPTY;
      end else if (w_load) begin
        for (int k = 0; k < NUM_SLOTS; k++)
          if (w_sel[k]) r_card[k] <= w_drawn_rank;
      end
      if ((new_hand && (|w_ld)) || w_multi || (w_load && w_overwrite))
        r_protocol_err <= 1'b1;
      if (w_load && w_empty)
        r_shoe_empty <= 1'b1;
    end
  end

  assign pcard1 = r_card[SLOT_P1];
  assign dcard1 = r_card[SLOT_D1];
  assign pcard2 = r_card[SLOT_P2];
  assign dcard2 = r_card[SLOT_D2];
  assign pcard3 = r_card[SLOT_P3];
  assign dcard3 = r_card[SLOT_D3];

  assign pscore = score_mod10(5'(card_value(pcard1)) + 5'(card_value(pcard2)) + 5'(card_value(pcard3)));
  assign dscore = score_mod10(5'(card_value(dcard1)) + 5'(card_value(dcard2)) + 5'(card_value(dcard3)));

  assign cards_left   = w_cards_left;
  assign protocol_err = r_protocol_err;
  assign shoe_empty   = r_shoe_empty;
endmodule

// File: tb/tb_card_datapath.sv
// Scoreboard bench for card_datapath: directed strobe sequences, queued expectations, negedge monitor.
module tb_card_datapath;
  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic [5:0] ld = '0;
  logic       nh = 1'b0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
  logic [7:0] cards_left;
  logic       protocol_err, shoe_empty;

  localparam logic [5:0] P1 = 6'b000001, D1 = 6'b000010, P2 = 6'b000100;
  localparam logic [5:0] D2 = 6'b001000, NONE = 6'b000000;
  localparam int S_P1 = 0, S_P2 = 1, S_P3 = 2, S_D1 = 3, S_D2 = 4, S_D3 = 5;
  localparam int S_PS = 6, S_DS = 7, S_CL = 8, S_PE = 9, S_SE = 10;

  typedef struct {
    string name;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   edges = 0;

  always #5 clk = ~clk;

  card_datapath #(.NUM_DECKS(1)) dut (
    .clk(clk), .resetb(resetb),
    .load_pcard1(ld[0]), .load_dcard1(ld[1]), .load_pcard2(ld[2]),
    .load_dcard2(ld[3]), .load_pcard3(ld[4]), .load_dcard3(ld[5]),
    .new_hand(nh),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore), .cards_left(cards_left),
    .protocol_err(protocol_err), .shoe_empty(shoe_empty)
  );

  function automatic int actual(input int sel);
    case (sel)
      S_P1: return int'(pcard1);
      S_P2: return int'(pcard2);
      S_P3: return int'(pcard3);
      S_D1: return int'(dcard1);
      S_D2: return int'(dcard2);
      S_D3: return int'(dcard3);
      S_PS: return int'(pscore);
      S_DS: return int'(dscore);
      S_CL: return int'(cards_left);
      S_PE: return int'(protocol_err);
      default: return int'(shoe_empty);
    endcase
  endfunction

  // Monitor: drains every queued expectation at the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() != 0) begin
      exp_t e;
      int   a;
      e = sb_q.pop_front();
      a = actual(e.sel);
      n_vec++;
      if (a != e.exp) begin
        n_mis++;
        $display("FAIL %s: got %0d, required %0d (t=%0t)", e.name, a, e.exp, $time);
      end else begin
        $display("ok   %s = %0d", e.name, a);
      end
    end
  end

  task automatic expect_v(input string name, input int sel, input int v);
    sb_q.push_back('{name, sel, v});
  endtask

  task automatic step(input logic [5:0] strobes, input logic hand);
    ld = strobes;
    nh = hand;
    @(posedge clk);
    edges++;
    #1;
    ld = NONE;
    nh = 1'b0;
  endtask

  task automatic idle_until(input int n);
    while (edges < n - 1) step(NONE, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetb = 1'b0;
    ld = NONE;
    nh = 1'b0;
    #1;
    expect_v("rst_pcard1", S_P1, 0); expect_v("rst_pcard2", S_P2, 0);
    expect_v("rst_pcard3", S_P3, 0); expect_v("rst_dcard1", S_D1, 0);
    expect_v("rst_dcard2", S_D2, 0); expect_v("rst_dcard3", S_D3, 0);
    expect_v("rst_pscore", S_PS, 0); expect_v("rst_dscore", S_DS, 0);
    expect_v("rst_cards_left", S_CL, 52);
    expect_v("rst_protocol_err", S_PE, 0); expect_v("rst_shoe_empty", S_SE, 0);
    @(negedge clk);
    #1;
    resetb = 1'b1;
    edges = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  initial begin
    // Basic draw and face cards
    do_reset();
    step(P1, 1'b0);
    expect_v("basic_pcard1", S_P1, 1); expect_v("basic_pscore1", S_PS, 1);
    expect_v("basic_left51", S_CL, 51);
    idle_until(9);
    step(P2, 1'b0);
    expect_v("basic_pcard2", S_P2, 9); expect_v("basic_pscore0", S_PS, 0);
    expect_v("basic_left50", S_CL, 50);
    step(D1, 1'b0);
    expect_v("face_dcard1", S_D1, 10); expect_v("face_dscore0", S_DS, 0);
    idle_until(17);
    step(D2, 1'b0);
    expect_v("face_dcard2", S_D2, 4); expect_v("face_dscore4", S_DS, 4);
    expect_v("face_left48", S_CL, 48); expect_v("face_no_err", S_PE, 0);
    step(NONE, 1'b1);
    expect_v("nh_pcard1", S_P1, 0); expect_v("nh_dcard2", S_D2, 0);
    expect_v("nh_pscore", S_PS, 0); expect_v("nh_left48", S_CL, 48);
    // Simultaneous strobes at edge 19 (ctr = 6)
    step(P2 | D1, 1'b0);
    expect_v("simul_dcard1", S_D1, 6); expect_v("simul_pcard2", S_P2, 0);
    expect_v("simul_dscore", S_DS, 6); expect_v("simul_left47", S_CL, 47);
    expect_v("simul_err", S_PE, 1);

    // Held strobe overwrites and flags
    do_reset();
    step(P1, 1'b0);
    expect_v("hold_first_err", S_PE, 0);
    step(P1, 1'b0);
    expect_v("hold_pcard1", S_P1, 2); expect_v("hold_err", S_PE, 1);
    expect_v("hold_left50", S_CL, 50);

    // Strobe coinciding with new_hand is ignored
    do_reset();
    step(D1, 1'b1);
    expect_v("nhld_dcard1", S_D1, 0); expect_v("nhld_left52", S_CL, 52);
    expect_v("nhld_err", S_PE, 1);

    // Ace exhaustion at edges 1,14,27,40 then rank 2 at edge 53
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle_until(1 + 13 * k);
      step(P1, 1'b0);
      expect_v($sformatf("exh_ace%0d", k), S_P1, 1);
      step(NONE, 1'b1);
    end
    idle_until(53);
    step(P1, 1'b0);
    expect_v("exh_rank2", S_P1, 2); expect_v("exh_left47", S_CL, 47);
    expect_v("exh_no_err", S_PE, 0);

    // Reshuffle at 5 left, none at 6 left
    do_reset();
    repeat (47) step(P1, 1'b0);
    expect_v("shuf_left5", S_CL, 5);
    step(NONE, 1'b1);
    expect_v("shuf_pcard1", S_P1, 0); expect_v("shuf_left52", S_CL, 52);
    step(P1, 1'b0);
    expect_v("shuf_draw_rank10", S_P1, 10); expect_v("shuf_left51", S_CL, 51);
    repeat (45) step(P1, 1'b0);
    expect_v("noshuf_left6", S_CL, 6);
    step(NONE, 1'b1);
    expect_v("noshuf_keep6", S_CL, 6); expect_v("noshuf_pcard1", S_P1, 0);

    // Empty shoe
    do_reset();
    repeat (52) step(P1, 1'b0);
    expect_v("empty_left0", S_CL, 0); expect_v("empty_flag_pre", S_SE, 0);
    step(P1, 1'b0);
    expect_v("empty_pcard1", S_P1, 0); expect_v("empty_flag", S_SE, 1);
    expect_v("empty_left_still0", S_CL, 0);
    do_reset();

    @(negedge clk);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
